// File: rtl/regfile_pkg.sv
`default_nettype none
// ==== regfile_pkg : shared types and defaults for regfile_sb ==== rev 1.0
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;
endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ==== regfile_sb_if : read/write/scoreboard bus of regfile_sb ==== rev 1.0
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
);
  localparam int AW = $clog2(NREG);

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            w_e;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] data_in;
  logic            alloc_v;
  logic [AW-1:0]   alloc_rd;
  logic            busy1;
  logic            busy2;
  logic            clr_req;
  logic            ready;

  modport master (
    output rs1, rs2, w_e, rd, data_in, alloc_v, alloc_rd, clr_req,
    input  rdata1, rdata2, busy1, busy2, ready
  );

  modport slave (
    input  rs1, rs2, w_e, rd, data_in, alloc_v, alloc_rd, clr_req,
    output rdata1, rdata2, busy1, busy2, ready
  );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ==== regfile_scoreboard : pending-destination bit vector ==== rev 1.0
module regfile_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          set_v,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_v,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] q1_idx,
  input  logic [AW-1:0] q2_idx,
  output logic          q1,
  output logic          q2
);
  localparam logic [NREG-1:0] ONE = NREG'(1);

  logic [NREG-1:0] bits;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  assign set_mask = set_v ? (ONE << set_idx) : '0;
  assign clr_mask = clr_v ? (ONE << clr_idx) : '0;

  // Set is OR-ed after the clear so a same-cycle alloc wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits <= '0;
    end else if (clr) begin
      bits <= '0;
    end else begin
      bits <= (bits & ~clr_mask) | set_mask;
    end
  end

  assign q1 = bits[q1_idx] & ~(clr_v && (clr_idx == q1_idx));
  assign q2 = bits[q2_idx] & ~(clr_v && (clr_idx == q2_idx));
endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ==== regfile_sb : 2R1W register file with sweep clear and scoreboard ==== rev 1.0
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);
  localparam int            AW       = $clog2(NREG);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_e        state;
  state_e        state_nxt;
  logic [AW-1:0] clr_idx;
  logic [AW-1:0] clr_idx_nxt;
  logic          sb_clr;
  logic          run;
  logic          wr_ok;
  logic          alloc_ok;
  logic          zero1;
  logic          zero2;
  logic          sb_q1;
  logic          sb_q2;

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    sb_clr      = 1'b0;
    case (state)
      CLEAR: begin
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == LAST_IDX) state_nxt = RUN;
      end
      RUN: begin
        if (bus.clr_req) begin
          state_nxt   = CLEAR;
          clr_idx_nxt = '0;
          sb_clr      = 1'b1;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign run      = (state == RUN);
  assign wr_ok    = run && bus.w_e && !((ZERO_REG != 0) && (bus.rd == '0));
  assign alloc_ok = run && bus.alloc_v && !((ZERO_REG != 0) && (bus.alloc_rd == '0));
  assign zero1    = (ZERO_REG != 0) && (bus.rs1 == '0);
  assign zero2    = (ZERO_REG != 0) && (bus.rs2 == '0);

  // No reset on the array: contents are established by the CLEAR sweep.
  always_ff @(posedge clk) begin
    if (!run) begin
      regs[clr_idx] <= '0;
    end else if (wr_ok) begin
      regs[bus.rd] <= bus.data_in;
    end
  end

  assign bus.rdata1 = (!run || zero1) ? '0 :
                      (bus.w_e && (bus.rd == bus.rs1)) ? bus.data_in : regs[bus.rs1];
  assign bus.rdata2 = (!run || zero2) ? '0 :
                      (bus.w_e && (bus.rd == bus.rs2)) ? bus.data_in : regs[bus.rs2];

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .clr     (sb_clr),
    .set_v   (alloc_ok),
    .set_idx (bus.alloc_rd),
    .clr_v   (wr_ok),
    .clr_idx (bus.rd),
    .q1_idx  (bus.rs1),
    .q2_idx  (bus.rs2),
    .q1      (sb_q1),
    .q2      (sb_q2)
  );

  assign bus.busy1 = run & sb_q1;
  assign bus.busy2 = run & sb_q2;
  assign bus.ready = run;
endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ==== tb_regfile_sb : directed self-checking bench for regfile_sb ==== rev 1.0
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .NREG(32)) bus ();

  regfile_sb #(.XLEN(32), .NREG(32), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.w_e = 1'b0; bus.alloc_v = 1'b0; bus.clr_req = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!bus.ready && cnt < 200) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    bus.rs1 = 5; bus.rs2 = 0; bus.rd = 0; bus.data_in = 0; bus.alloc_rd = 0;
    idle();
    step(); step();
    chk("reset_ready", {31'd0, bus.ready}, 32'd0);
    chk("reset_rdata1", bus.rdata1, 32'd0);
    chk("reset_busy1", {31'd0, bus.busy1}, 32'd0);

    rst = 1'b0;
    wait_ready(n);
    chk("init_sweep_len", n, 32'd32);
    bus.rs1 = 5; #1;
    chk("init_r5_zero", bus.rdata1, 32'd0);

    // Write-through bypass and persistence
    bus.w_e = 1; bus.rd = 7; bus.data_in = 32'hDEADBEEF; bus.rs1 = 7; bus.rs2 = 7; #1;
    chk("bypass_r7", bus.rdata1, 32'hDEADBEEF);
    chk("bypass_r7_b", bus.rdata2, 32'hDEADBEEF);
    step(); idle(); #1;
    chk("stored_r7", bus.rdata1, 32'hDEADBEEF);

    // Register 0 is hardwired
    bus.w_e = 1; bus.rd = 0; bus.data_in = 32'h1234; bus.rs1 = 0; #1;
    chk("r0_same_cycle", bus.rdata1, 32'd0);
    step(); idle(); #1;
    chk("r0_after", bus.rdata1, 32'd0);
    bus.alloc_v = 1; bus.alloc_rd = 0; step(); idle(); #1;
    chk("r0_never_busy", {31'd0, bus.busy1}, 32'd0);

    // Scoreboard: alloc then write
    bus.alloc_v = 1; bus.alloc_rd = 9; bus.rs1 = 9; bus.rs2 = 9; #1;
    chk("alloc_not_yet_visible", {31'd0, bus.busy1}, 32'd0);
    step(); idle(); #1;
    chk("busy_after_alloc", {31'd0, bus.busy1}, 32'd1);
    bus.w_e = 1; bus.rd = 9; bus.data_in = 32'h55; #1;
    chk("busy_cleared_in_write", {31'd0, bus.busy1}, 32'd0);
    step(); idle(); #1;
    chk("busy_after_write", {31'd0, bus.busy1}, 32'd0);
    chk("r9_data", bus.rdata1, 32'h55);
    bus.alloc_v = 1; bus.alloc_rd = 9; bus.w_e = 1; bus.rd = 9; bus.data_in = 32'h66; #1;
    step(); idle(); #1;
    chk("alloc_wins_busy1", {31'd0, bus.busy1}, 32'd1);
    chk("alloc_wins_busy2", {31'd0, bus.busy2}, 32'd1);
    chk("alloc_wins_data", bus.rdata1, 32'h66);

    // Clear request
    bus.w_e = 1; bus.rd = 3; bus.data_in = 32'hAA; step(); idle();
    bus.rs1 = 3; #1;
    chk("r3_written", bus.rdata1, 32'hAA);
    bus.clr_req = 1; step(); idle(); #1;
    chk("clr_ready_low", {31'd0, bus.ready}, 32'd0);
    chk("clr_rdata_zero", bus.rdata1, 32'd0);
    chk("clr_busy_zero", {31'd0, bus.busy2}, 32'd0);
    n = 0;
    while (!bus.ready && n < 200) begin
      if (n == 5) bus.clr_req = 1;
      if (n == 10) begin bus.w_e = 1; bus.rd = 4; bus.data_in = 32'h77; end
      step(); idle();
      n++;
    end
    chk("clr_sweep_len", n, 32'd32);
    bus.rs1 = 3; bus.rs2 = 9; #1;
    chk("r3_cleared", bus.rdata1, 32'd0);
    chk("busy_cleared", {31'd0, bus.busy2}, 32'd0);
    bus.rs1 = 4; #1;
    chk("write_ignored_in_clear", bus.rdata1, 32'd0);

    // Reset in the middle of a sweep
    bus.w_e = 1; bus.rd = 12; bus.data_in = 32'h42; step(); idle();
    bus.clr_req = 1; step(); idle();
    repeat (10) step();
    rst = 1'b1; #1;
    chk("midsweep_rst_ready", {31'd0, bus.ready}, 32'd0);
    step(); step();
    rst = 1'b0;
    wait_ready(n);
    chk("restart_sweep_len", n, 32'd32);
    bus.rs1 = 12; #1;
    chk("r12_cleared", bus.rdata1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count, power of two, at least 4.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as zero and is never written or marked busy.
REQ-004 SHALL have localparam AW = clog2(NREG).
REQ-005 SHALL have one clock and an asynchronous active-high reset: clk  in  1  clock; rst  in  1  async reset, active high.
REQ-006 SHALL have these ports: rs1  in  AW  read address A; rs2  in  AW  read address B.
REQ-007 SHALL have these ports: rdata1  out  XLEN  read data A; rdata2  out  XLEN  read data B.
REQ-008 SHALL have these ports: w_e  in  1  write enable; rd  in  AW  write address; data_in  in  XLEN  write data.
REQ-009 SHALL have these ports: alloc_v  in  1  mark a destination pending; alloc_rd  in  AW  destination to mark.
REQ-010 SHALL have these ports: busy1  out  1  rs1 pending; busy2  out  1  rs2 pending.
REQ-011 SHALL have these ports: clr_req  in  1  request a full clear; ready  out  1  block is in RUN.

Function
REQ-012 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-013 In CLEAR, SHALL write zero to register clr_idx on each clk edge, increment clr_idx, and enter RUN after index NREG-1 is written, so CLEAR lasts NREG cycles.
REQ-014 In RUN, an asserted clr_req SHALL reset clr_idx to 0 and enter CLEAR on the next edge; clr_req SHALL be ignored in CLEAR.
REQ-015 ready SHALL be 1 only in RUN.
REQ-016 In CLEAR, SHALL drive rdata1, rdata2, busy1 and busy2 to 0 and ignore w_e and alloc_v.
REQ-017 In RUN with w_e=1, SHALL write data_in to registers[rd] on the edge, except rd=0 when ZERO_REG=1.
REQ-018 Reads SHALL be combinational.
REQ-019 A read SHALL return data_in when w_e=1 and the read address equals rd (write-through bypass), subject to REQ-020.
REQ-020 When ZERO_REG=1, a read of address 0 SHALL return 0 regardless of any bypass.
REQ-021 SHALL keep an NREG-bit scoreboard; alloc_v SHALL set bit alloc_rd on the edge, and w_e SHALL clear bit rd on the edge.
REQ-022 When alloc_v and w_e target the same register in the same cycle, the bit SHALL remain set (alloc wins) and data_in SHALL still be written.
REQ-023 busy1 and busy2 SHALL reflect the scoreboard bit after the same-cycle w_e clear, so they read 0 when the write targets that address; a same-cycle alloc SHALL be visible only after the edge.
REQ-024 Entering CLEAR, whether by clr_req or reset, SHALL zero the scoreboard.

Reset
REQ-025 While rst=1: state=CLEAR, clr_idx=0, scoreboard=0, ready=0, and rdata1, rdata2, busy1, busy2 all 0.
REQ-026 Reset SHALL NOT clear the array directly; the array SHALL be zeroed by the CLEAR sweep that follows deassertion.
REQ-027 rst asserted in the middle of a sweep SHALL restart the sweep at index 0.

Structure
REQ-028 A shared package regfile_pkg SHALL hold the FSM state enum (CLEAR, RUN) and the defaults XLEN_DEF=32 and NREG_DEF=32.
REQ-029 The scoreboard SHALL be a sub-module, regfile_scoreboard, with ports clk, rst, clr, set_v, set_idx, clr_v, clr_idx, q1_idx, q2_idx, q1 and q2.
REQ-030 The array SHALL be a plain register array without reset, so it can map to distributed RAM.

Verification
REQ-031 Release rst and count cycles: ready rises exactly 32 cycles after deassertion, and rs1=5 then reads 0x0.
REQ-032 In RUN, apply w_e=1, rd=7, data_in=0xDEADBEEF with rs1=7 in the same cycle: rdata1=0xDEADBEEF in that cycle and after the edge.
REQ-033 Write 0x1234 to rd=0: rdata1 at rs1=0 is 0 both in the same cycle and afterwards.
REQ-034 Apply alloc_v at register 9, then the next cycle w_e at rd=9: busy1 at rs1=9 is 1 after the first edge and 0 in the write cycle; alloc and write to register 9 together leave busy1=1.
REQ-035 Pulse clr_req after writing 0xAA to register 3: ready drops for 32 cycles, and register 3 then reads 0 with busy bits at 0.
REQ-036 Assert rst at sweep index 10 for 2 cycles: after release, ready rises only after a further full 32 cycles.
